// File: rtl/fractal_sync_cnt_local_rf.sv
// fractal_sync_cnt_local_rf: counting N-party local barrier register file with merged same-cycle arrivals
module fractal_sync_cnt_local_rf #(
    parameter int N_REGS         = 4,
    parameter int ID_WIDTH       = 3,
    parameter int N_PORTS        = 4,
    parameter int CNT_WIDTH      = 3,
    parameter int DEFAULT_TARGET = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_PORTS-1:0]                 req_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]   id_i,
    output logic [N_PORTS-1:0]                 rsp_valid_o,
    output logic [N_PORTS-1:0]                 rsp_done_o,
    output logic [N_PORTS-1:0]                 rsp_err_o,
    input  logic                               cfg_we_i,
    input  logic [ID_WIDTH-2:0]                cfg_idx_i,
    input  logic [CNT_WIDTH-1:0]               cfg_target_i,
    output logic                               cfg_err_o,
    output logic [N_REGS-1:0]                  done_o,
    output logic [N_REGS-1:0]                  pending_o
);
    localparam int IW = ID_WIDTH - 1;
    localparam logic [IW:0] NR = (IW+1)'(N_REGS);
    logic [CNT_WIDTH-1:0] cnt    [N_REGS];
    logic [CNT_WIDTH-1:0] target [N_REGS];
    logic [CNT_WIDTH:0]   acc    [N_REGS];
    logic [N_REGS-1:0]    closed, blocked;
    logic [N_PORTS-1:0]   done_d, err_d;
    always_comb begin
        done_d = '0;
        err_d  = '0;
        for (int r = 0; r < N_REGS; r++) begin
            acc[r]     = {1'b0, cnt[r]};
            closed[r]  = 1'b0;
            blocked[r] = (target[r] == '0) || (cfg_we_i && cfg_idx_i == IW'(r));
        end
        // ascending port order: the port reaching target completes, later ones are excess
        for (int p = 0; p < N_PORTS; p++) begin
            if (req_i[p]) begin
                err_d[p] = 1'b1;
                for (int r = 0; r < N_REGS; r++) begin
                    if (id_i[p][ID_WIDTH-1:1] == IW'(r) && !blocked[r] && !closed[r]) begin
                        err_d[p] = 1'b0;
                        if (acc[r] + (CNT_WIDTH+1)'(1) == {1'b0, target[r]}) begin
                            done_d[p] = 1'b1;
                            closed[r] = 1'b1;
                        end else begin
                            acc[r] = acc[r] + (CNT_WIDTH+1)'(1);
                        end
                    end
                end
            end
        end
    end
    always_comb begin
        for (int r = 0; r < N_REGS; r++) pending_o[r] = cnt[r] != '0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= '0;
            rsp_done_o  <= '0;
            rsp_err_o   <= '0;
            done_o      <= '0;
            cfg_err_o   <= 1'b0;
            for (int r = 0; r < N_REGS; r++) begin
                cnt[r]    <= '0;
                target[r] <= CNT_WIDTH'(DEFAULT_TARGET);
            end
        end else begin
            rsp_valid_o <= req_i;
            rsp_done_o  <= done_d;
            rsp_err_o   <= err_d;
            done_o      <= closed;
            cfg_err_o   <= cfg_we_i && ({1'b0, cfg_idx_i} >= NR);
            for (int r = 0; r < N_REGS; r++) begin
                if (cfg_we_i && cfg_idx_i == IW'(r)) begin
                    target[r] <= cfg_target_i;
                    cnt[r]    <= '0;
                end else begin
                    cnt[r] <= closed[r] ? '0 : acc[r][CNT_WIDTH-1:0];
                end
            end
        end
    end
endmodule
